// File: rtl/c2_serial_subtractor.sv
// Bit-serial unsigned subtractor: computes i1 - i2 LSB first, one bit per clock.
// Result is packed as {borrow, difference}, matching the ripple-carry adder layout.
module c2_serial_subtractor #(
  parameter int unsigned size = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] i1,
  input  logic [size-1:0] i2,
  output logic [size:0]   o,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CntW = $clog2(size);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [size-1:0]   a_q, a_d;
  logic [size-1:0]   b_q, b_d;
  logic [size-1:0]   diff_q, diff_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [size:0]     o_q, o_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              d_bit;
  logic              br_next;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = i1;
          b_d     = i2;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {d_bit, diff_q[size-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: publish the result including the bit computed this cycle.
        if (cnt_q == CntW'(size - 1)) begin
          o_d     = {br_next, d_bit, diff_q[size-1:1]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_c2_serial_subtractor.sv
// Scoreboard bench for c2_serial_subtractor at size 5 (directed + exhaustive) and size 8 (random).
module tb_c2_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst5 = 1'b1, start5 = 1'b0;
  logic [4:0] i1_5 = '0, i2_5 = '0;
  logic [5:0] o5;
  logic       busy5, done5;
  logic       rst8 = 1'b1, start8 = 1'b0;
  logic [7:0] i1_8 = '0, i2_8 = '0;
  logic [8:0] o8;
  logic       busy8, done8;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m5_rem = 0;
  int m8_rem = 0;
  logic [5:0] q5[$];
  int         qc5[$];
  logic [8:0] q8[$];
  int         qc8[$];

  always #5 clk = ~clk;

  c2_serial_subtractor #(.size(5)) u_dut5 (
    .clk(clk), .rst(rst5), .start(start5), .i1(i1_5), .i2(i2_5),
    .o(o5), .busy(busy5), .done(done5)
  );

  c2_serial_subtractor #(.size(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .i1(i1_8), .i2(i2_8),
    .o(o8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference timing model: accepts start only when idle, result due size edges later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst5) begin
      m5_rem <= 0;
      q5.delete();
      qc5.delete();
    end else if (m5_rem == 0) begin
      if (start5) begin
        m5_rem <= 5;
        q5.push_back({i1_5 < i2_5, 5'(i1_5 - i2_5)});
        qc5.push_back(cyc + 1 + 5);
      end
    end else begin
      m5_rem <= m5_rem - 1;
    end
    if (rst8) begin
      m8_rem <= 0;
      q8.delete();
      qc8.delete();
    end else if (m8_rem == 0) begin
      if (start8) begin
        m8_rem <= 8;
        q8.push_back({i1_8 < i2_8, 8'(i1_8 - i2_8)});
        qc8.push_back(cyc + 1 + 8);
      end
    end else begin
      m8_rem <= m8_rem - 1;
    end
  end

  always @(negedge clk) begin
    logic exp_d5, exp_d8;
    if (cyc > 0) begin
      exp_d5 = (qc5.size() != 0) && (qc5[0] == cyc);
      check("busy5", busy5, m5_rem != 0);
      check("done5", done5, exp_d5);
      if (exp_d5) begin
        check("o5", o5, q5[0]);
        void'(q5.pop_front());
        void'(qc5.pop_front());
      end
      exp_d8 = (qc8.size() != 0) && (qc8[0] == cyc);
      check("busy8", busy8, m8_rem != 0);
      check("done8", done8, exp_d8);
      if (exp_d8) begin
        check("o8", o8, q8[0]);
        void'(q8.pop_front());
        void'(qc8.pop_front());
      end
    end
  end

  task automatic op5(input logic [4:0] a, input logic [4:0] b);
    int n = 0;
    @(negedge clk);
    while (m5_rem != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("op5_wait", 1, 0);
    start5 = 1'b1;
    i1_5   = a;
    i2_5   = b;
    @(negedge clk);
    start5 = 1'b0;
    i1_5   = 5'($urandom);
    i2_5   = 5'($urandom);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (m8_rem != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("op8_wait", 1, 0);
    start8 = 1'b1;
    i1_8   = a;
    i2_8   = b;
    @(negedge clk);
    start8 = 1'b0;
    i1_8   = 8'($urandom);
    i2_8   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m5_rem != 0 || m8_rem != 0 || q5.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst5 = 1'b0;
    rst8 = 1'b0;
    check("rst_o5", o5, 0);
    check("rst_busy5", busy5, 0);
    check("rst_done5", done5, 0);
    check("rst_o8", o8, 0);

    // Directed cases, back-to-back.
    op5(5'd9, 5'd3);
    op5(5'd3, 5'd9);
    op5(5'd0, 5'd1);
    op5(5'd31, 5'd31);
    wait_idle();
    check("o5_zero_hold", o5, 6'b000000);

    // Start held high with fresh operands every cycle.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start5 = 1'b1;
      i1_5   = 5'($urandom);
      i2_5   = 5'($urandom);
    end
    @(negedge clk);
    start5 = 1'b0;
    wait_idle();

    // Result held while busy, then reset aborts a run.
    op5(5'd5, 5'd2);
    op5(5'd12, 5'd4);
    @(negedge clk);
    check("o5_hold_busy", o5, 6'b000011);
    @(negedge clk);
    rst5 = 1'b1;
    @(negedge clk);
    rst5 = 1'b0;
    check("abort_o5", o5, 0);
    check("abort_busy5", busy5, 0);
    check("abort_done5", done5, 0);
    op5(5'd20, 5'd7);
    wait_idle();
    check("o5_after_abort", o5, 6'b001101);

    // Exhaustive size-5 sweep.
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        op5(5'(a), 5'(b));
    wait_idle();

    // Random size-8 sweep plus edge values.
    op8(8'd0, 8'd255);
    op8(8'd255, 8'd0);
    for (int k = 0; k < 200; k++) op8(8'($urandom), 8'($urandom));
    wait_idle();

    repeat (3) @(negedge clk);
    check("q5_empty", q5.size(), 0);
    check("q8_empty", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c2_serial_subtractor.md
Name: c2_serial_subtractor

Overview:
- Multi-cycle, bit-serial unsigned subtractor. Computes i1 - i2 one bit per clock, LSB first, with a single registered borrow flop.
- It is the inverse companion of the datapath's combinational ripple-carry adder. The result uses the same {carry/borrow, sum} packing: o = {borrow_out, difference}.
- Used where subtract is needed but area matters more than latency: compare/restore steps and accumulator decrement.

Parameters:
size, 5, operand width in bits (>= 2); the result is size+1 bits wide.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
i1  input  size  minuend, unsigned; sampled on the cycle start is accepted.
i2  input  size  subtrahend, unsigned; sampled on the cycle start is accepted.
o  output  size+1  registered result {borrow, i1 - i2 mod 2^size}.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse marking that o has just been updated.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Nothing happens asynchronously.
- Reset (rst high at a rising edge):
  - state = IDLE; o = 0, busy = 0, done = 0.
  - Internal shift registers, borrow flop and bit counter all cleared.
  - rst takes priority over every other input.
- FSM has two states, IDLE and RUN.
- IDLE:
  - If start = 1 at edge N: load a_sr <= i1, b_sr <= i2, br <= 0, cnt <= 0, busy <= 1, go to RUN.
  - If start = 0: stay in IDLE, busy = 0.
- RUN, at each edge:
  - Take a0 = a_sr[0], b0 = b_sr[0].
  - Difference bit d = a0 ^ b0 ^ br.
  - Next borrow br <= (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift a_sr and b_sr right by 1. Shift d into the MSB of diff_sr, which shifts right.
  - cnt <= cnt + 1. cnt is wide enough to hold size-1.
- Completion, on the RUN edge where cnt == size-1 (the size-th bit):
  - o <= {borrow_next, final diff}. This is the full registered result, including the current bit.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge N; o valid and done = 1 after edge N+size. Next start can be accepted at edge N+size+1, so throughput is one operation per size+1 cycles.
- done is high for exactly one cycle, then cleared. A start sampled on the done cycle is legal and is accepted in IDLE.
- o holds its last value until the next completion. It does not change while busy.
- start while busy: ignored. Operands are not resampled and the current operation is unaffected.
- i1 and i2 may change freely after the accept edge.
- Arithmetic rules:
  - o[size] = 1 exactly when i1 < i2 (unsigned).
  - o[size-1:0] = (i1 - i2) mod 2^size.
  - Equivalently, o = {i1 < i2, i1 + ~i2 + 1 truncated}.
- Reset mid-operation: the operation is aborted and no done is issued. Outputs return to their reset values. The next start behaves as if fresh.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset, then start with i1=9, i2=3 (size=5) -> exactly 5 cycles later done=1 for one cycle, o=6'b000110; busy high for the 5 intervening cycles.
- i1=3, i2=9 -> o=6'b111010 (borrow=1, diff=26). Also i1=0, i2=1 -> o=6'b111111. Also i1=31, i2=31 -> o=0.
- Hold start=1 continuously with new operands each cycle -> accepted only in IDLE (every 6 cycles). Mid-run operand changes have no effect, and each done shows the result of the operands sampled at acceptance.
- Assert rst at cycle 2 of a RUN -> next edge o=0, busy=0, no done pulse. A subsequent start with 20-7 yields o=6'b001101.
- Exhaustive sweep of all 1024 (i1,i2) pairs at size=5 against a reference model of {i1<i2, (i1-i2)&31}. Random sweep at size=8 against {i1<i2, (i1-i2)&255} with 8-cycle latency checked.
- Back-to-back: issue start on the same cycle done pulses -> accepted, and the next done arrives size+1 cycles after the previous one.
